mem2_bus_arbiter: RTL and testbench
===================================

// Module: mem2_bus_arbiter
// PURPOSE
//  Owns memory port 2 (data port) and shares it between the CPU data path and the DMA engine.
//  Runs the BR/BG handshake: a DMA request is granted only at a CPU access boundary.
//  CPU data accesses are stalled while DMA owns the bus.
//  Drives the read/write/address lines of memory port 2 and the data-direction select.
//  Sits between cpu, DMA_control/external_device and Memory, replacing ad-hoc BG muxing.
// PARAMETERS
//  WORD_SIZE      16  address width
//  MEM_LATENCY    4   cycles per CPU memory access on port 2 (>=1)
//  MAX_CPU_BURST  4   back-to-back CPU accesses allowed while BR is pending before DMA is forced in (>=1)
// PORTS
//  clk            in   1          rising-edge clock
//  reset_n        in   1          asynchronous, active-low reset
//  cpu_read_m2    in   1          CPU data read request, held until cpu_done
//  cpu_write_m2   in   1          CPU data write request, held until cpu_done
//  cpu_address2   in   WORD_SIZE  CPU data address
//  br             in   1          DMA bus request, level; held for the whole DMA transfer
//  dma_write      in   1          DMA write strobe (valid only while bg=1)
//  dma_address    in   WORD_SIZE  DMA write address
//  bg             out  1          bus grant to DMA, registered
//  cpu_stall      out  1          CPU request is pending but not being serviced
//  cpu_done       out  1          one-cycle pulse in the last cycle of a CPU access
//  mem_read_m2    out  1          to Memory port 2
//  mem_write_m2   out  1          to Memory port 2
//  mem_address2   out  WORD_SIZE  to Memory port 2
//  data_sel_dma   out  1          1 = port-2 data driven by the DMA/device, 0 = driven by the CPU
//  grant_cnt      out  16         number of DMA grants since reset; wraps at 0xFFFF -> 0
// BEHAVIOUR
//  Reset (async, reset_n=0):
//   - state=IDLE; lat_cnt=0; burst_cnt=0; grant_cnt=0; bg=0.
//   - All outputs are 0 while reset_n=0; bg drops immediately, even mid-transfer.
//  FSM states: IDLE, CPU_ACC, GRANT, DMA_OWN, RELEASE. creq = cpu_read_m2 | cpu_write_m2.
//   IDLE:
//    - br && (!creq || burst_cnt==MAX_CPU_BURST) -> GRANT.
//    - else creq -> CPU_ACC, with lat_cnt=0.
//    - CPU wins a simultaneous request unless the burst limit has been reached.
//   CPU_ACC:
//    - mem_read/write_m2 follow the CPU request; mem_address2=cpu_address2; lat_cnt increments.
//    - At lat_cnt==MEM_LATENCY-1: cpu_done=1.
//    - burst_cnt increments if br=1, is cleared if br=0.
//    - Next state is IDLE, so a new access can start the following cycle.
//   GRANT:
//    - One turnaround cycle with all memory strobes at 0.
//    - bg is set at the end of this cycle; grant_cnt increments; burst_cnt is cleared.
//    - If br has dropped by now: abort to IDLE without granting and without incrementing grant_cnt.
//   DMA_OWN:
//    - bg=1; data_sel_dma=1; mem_read_m2=0; mem_write_m2=dma_write; mem_address2=dma_address.
//    - br=0 -> RELEASE, and bg is cleared at that edge.
//   RELEASE:
//    - One turnaround cycle, strobes 0, then IDLE.
//  Timing and output rules:
//   - cpu_stall = creq && !(state==CPU_ACC). It is combinational and 0 during reset.
//   - Grant latency from br rising in IDLE with no creq: bg=1 two edges later.
//   - A CPU access in progress is never pre-empted. A br raised mid-access waits for the access boundary.
//   - A CPU request that changes address or direction mid-access is a protocol error. It is not checked; the address is sampled combinationally.
//   - data_sel_dma = bg.
//   - Memory address arithmetic (base + offset*4) stays in DMA_control; this block only passes dma_address through.
// STRUCTURE
//  Shared package/header mem2_arb_defs.vh holds:
//   - state encodings ARB_IDLE..ARB_RELEASE (3 bits);
//   - defaults for MEM_LATENCY and MAX_CPU_BURST.
//  One sub-module, arb_port_mux: purely combinational selection of read/write/address/data_sel from state.
//  FSM, lat_cnt, burst_cnt and grant_cnt stay in the top module.
// TESTING
//  1. CPU read alone (MEM_LATENCY=4) at 0x0040:
//     mem_read_m2=1 for 4 cycles; cpu_done pulses in cycle 4; cpu_stall=0; bg stays 0.
//  2. br rises in IDLE with no creq:
//     bg=1 two edges later; grant_cnt=1.
//     Then br falls: bg=0 next edge; one RELEASE cycle; then IDLE.
//  3. br rises in cycle 2 of a CPU write:
//     the write completes (cpu_done in cycle 4); then GRANT; then bg=1; the write is never truncated.
//  4. DMA owns the bus and the CPU raises cpu_read_m2:
//     cpu_stall=1 until DMA releases; after RELEASE the CPU access starts and cpu_stall=0.
//  5. Continuous creq with br held high, MAX_CPU_BURST=4:
//     exactly 4 CPU accesses complete, then bg=1; burst_cnt returns to 0.
//  6. reset_n pulled low while bg=1:
//     bg and all mem strobes go to 0 asynchronously; grant_cnt=0; state IDLE after release.

Source files
------------

// File: rtl/mem2_bus_arbiter_pkg.sv
// mem2_bus_arbiter_pkg: shared state encoding and parameter defaults for the port-2 arbiter
package mem2_bus_arbiter_pkg;
    typedef enum logic [2:0] {
        ARB_IDLE    = 3'd0,
        ARB_CPU_ACC = 3'd1,
        ARB_GRANT   = 3'd2,
        ARB_DMA_OWN = 3'd3,
        ARB_RELEASE = 3'd4
    } arb_state_t;
    localparam int DEF_MEM_LATENCY   = 4;
    localparam int DEF_MAX_CPU_BURST = 4;
endpackage

// File: rtl/mem2_bus_arbiter_arb_port_mux.sv
// arb_port_mux: combinational steering of memory port 2 strobes/address between CPU and DMA
//   state        in   arbiter state; CPU owns the port only in ARB_CPU_ACC
//   bg           in   registered DMA grant; DMA owns the port while set
//   cpu_*        in   CPU request lines and address
//   dma_*        in   DMA write strobe and address
//   mem_*        out  memory port 2 read/write/address
//   data_sel_dma out  data-direction select, mirrors bg
module arb_port_mux
    import mem2_bus_arbiter_pkg::*;
#(
    parameter int WORD_SIZE = 16
) (
    input  arb_state_t           state,
    input  logic                 bg,
    input  logic                 cpu_read,
    input  logic                 cpu_write,
    input  logic [WORD_SIZE-1:0] cpu_address,
    input  logic                 dma_write,
    input  logic [WORD_SIZE-1:0] dma_address,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic [WORD_SIZE-1:0] mem_address,
    output logic                 data_sel_dma
);
    logic cpu_own;
    always_comb begin
        cpu_own      = state == ARB_CPU_ACC;
        mem_read     = cpu_own && cpu_read;
        mem_write    = cpu_own ? cpu_write : bg && dma_write;
        mem_address  = cpu_own ? cpu_address : bg ? dma_address : '0;
        data_sel_dma = bg;
    end
endmodule

// File: rtl/mem2_bus_arbiter.sv
// mem2_bus_arbiter: shares memory port 2 between CPU data accesses and DMA via a BR/BG handshake
//   clk, reset_n               clock, asynchronous active-low reset
//   cpu_read_m2/cpu_write_m2   CPU request, held until cpu_done
//   cpu_address2               CPU data address
//   br                         DMA bus request (level)
//   dma_write, dma_address     DMA strobe/address, used while bg=1
//   bg                         registered bus grant
//   cpu_stall, cpu_done        CPU handshake
//   mem_read_m2/mem_write_m2/mem_address2, data_sel_dma   memory port 2
//   grant_cnt                  DMA grants since reset, wrapping
module mem2_bus_arbiter
    import mem2_bus_arbiter_pkg::*;
#(
    parameter int WORD_SIZE     = 16,
    parameter int MEM_LATENCY   = DEF_MEM_LATENCY,
    parameter int MAX_CPU_BURST = DEF_MAX_CPU_BURST
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 cpu_read_m2,
    input  logic                 cpu_write_m2,
    input  logic [WORD_SIZE-1:0] cpu_address2,
    input  logic                 br,
    input  logic                 dma_write,
    input  logic [WORD_SIZE-1:0] dma_address,
    output logic                 bg,
    output logic                 cpu_stall,
    output logic                 cpu_done,
    output logic                 mem_read_m2,
    output logic                 mem_write_m2,
    output logic [WORD_SIZE-1:0] mem_address2,
    output logic                 data_sel_dma,
    output logic [15:0]          grant_cnt
);
    localparam int LW = $clog2(MEM_LATENCY + 1);
    localparam int BW = $clog2(MAX_CPU_BURST + 1);
    arb_state_t    state, next_state;
    logic [LW-1:0] lat_cnt;
    logic [BW-1:0] burst_cnt;
    logic          creq, last, burst_max;
    assign creq      = cpu_read_m2 | cpu_write_m2;
    assign last      = state == ARB_CPU_ACC && lat_cnt == LW'(MEM_LATENCY - 1);
    // >= rather than ==: br can rise mid-access after an idle-time br=0, so the count may sit at the limit
    assign burst_max = burst_cnt >= BW'(MAX_CPU_BURST);
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) state <= ARB_IDLE;
        else state <= next_state;
    always_comb begin
        next_state = state;
        case (state)
            ARB_IDLE:    next_state = br && (!creq || burst_max) ? ARB_GRANT : creq ? ARB_CPU_ACC : ARB_IDLE;
            ARB_CPU_ACC: next_state = last ? ARB_IDLE : ARB_CPU_ACC;
            ARB_GRANT:   next_state = br ? ARB_DMA_OWN : ARB_IDLE;
            ARB_DMA_OWN: next_state = br ? ARB_DMA_OWN : ARB_RELEASE;
            default:     next_state = ARB_IDLE;
        endcase
    end
    always_comb begin
        cpu_stall = reset_n && creq && state != ARB_CPU_ACC;
        cpu_done  = last;
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lat_cnt   <= '0;
            burst_cnt <= '0;
            grant_cnt <= '0;
            bg        <= 1'b0;
        end else begin
            lat_cnt <= state == ARB_CPU_ACC ? lat_cnt + 1'b1 : '0;
            if (last) burst_cnt <= br ? (burst_max ? burst_cnt : burst_cnt + 1'b1) : '0;
            else if (state == ARB_GRANT) burst_cnt <= '0;
            if (state == ARB_GRANT && br) grant_cnt <= grant_cnt + 1'b1;
            bg <= next_state == ARB_DMA_OWN;
        end
    end
    arb_port_mux #(.WORD_SIZE(WORD_SIZE)) u_mux (
        .state        (state),
        .bg           (bg),
        .cpu_read     (cpu_read_m2),
        .cpu_write    (cpu_write_m2),
        .cpu_address  (cpu_address2),
        .dma_write    (dma_write),
        .dma_address  (dma_address),
        .mem_read     (mem_read_m2),
        .mem_write    (mem_write_m2),
        .mem_address  (mem_address2),
        .data_sel_dma (data_sel_dma)
    );
endmodule

// File: tb/tb_mem2_bus_arbiter.sv
// tb_mem2_bus_arbiter: vector table, directed corner sequences and randomized traffic vs a cycle model
module tb_mem2_bus_arbiter;
    localparam int LAT  = 4;
    localparam int MAXB = 4;
    logic        clk = 1'b0;
    logic        reset_n, rd, wr, br, dw;
    logic [15:0] caddr, daddr;
    logic        bg, cpu_stall, cpu_done, mem_read_m2, mem_write_m2, data_sel_dma;
    logic [15:0] mem_address2, grant_cnt;
    int          checks = 0, failures = 0;
    // model: cycles left in the current CPU access, turnaround flags, DMA ownership
    int          m_left, m_burst;
    bit          m_tin, m_own, m_tout;
    logic [15:0] m_grants;
    bit          last_done, seen_done, use_tab;
    typedef struct {
        logic        rd, wr, br, dw;
        logic [15:0] caddr, daddr;
        logic        e_bg, e_stall, e_done, e_rd, e_wr;
        logic [15:0] e_addr, e_gnt;
    } vec_t;
    vec_t tab[12];
    vec_t cur;

    mem2_bus_arbiter #(.WORD_SIZE(16), .MEM_LATENCY(LAT), .MAX_CPU_BURST(MAXB)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .cpu_read_m2  (rd),
        .cpu_write_m2 (wr),
        .cpu_address2 (caddr),
        .br           (br),
        .dma_write    (dw),
        .dma_address  (daddr),
        .bg           (bg),
        .cpu_stall    (cpu_stall),
        .cpu_done     (cpu_done),
        .mem_read_m2  (mem_read_m2),
        .mem_write_m2 (mem_write_m2),
        .mem_address2 (mem_address2),
        .data_sel_dma (data_sel_dma),
        .grant_cnt    (grant_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_left = 0; m_burst = 0; m_tin = 0; m_own = 0; m_tout = 0; m_grants = '0;
    endtask

    task automatic chk_model();
        bit busy;
        busy = m_left > 0;
        chk("bg", bg, m_own);
        chk("cpu_stall", cpu_stall, (rd | wr) && !busy);
        chk("cpu_done", cpu_done, m_left == 1);
        chk("mem_read", mem_read_m2, busy && rd);
        chk("mem_write", mem_write_m2, busy ? wr : m_own && dw);
        chk("mem_address", mem_address2, busy ? caddr : m_own ? daddr : 16'h0);
        chk("data_sel_dma", data_sel_dma, m_own);
        chk("grant_cnt", grant_cnt, m_grants);
    endtask

    task automatic model_step();
        if (m_left > 0) begin
            if (m_left == 1) m_burst = br ? (m_burst < MAXB ? m_burst + 1 : MAXB) : 0;
            m_left--;
        end else if (m_tin) begin
            m_tin = 0;
            m_burst = 0;
            if (br) begin m_own = 1; m_grants++; end
        end else if (m_own) begin
            if (!br) begin m_own = 0; m_tout = 1; end
        end else if (m_tout) m_tout = 0;
        else if (br && (!(rd | wr) || m_burst >= MAXB)) m_tin = 1;
        else if (rd | wr) m_left = LAT;
    endtask

    task automatic cyc();
        @(negedge clk);
        chk_model();
        last_done = m_left == 1;
        seen_done = cpu_done;
        if (use_tab) begin
            chk("tab_bg", bg, cur.e_bg);
            chk("tab_stall", cpu_stall, cur.e_stall);
            chk("tab_done", cpu_done, cur.e_done);
            chk("tab_rd", mem_read_m2, cur.e_rd);
            chk("tab_wr", mem_write_m2, cur.e_wr);
            chk("tab_addr", mem_address2, cur.e_addr);
            chk("tab_gnt", grant_cnt, cur.e_gnt);
        end
        @(posedge clk);
        model_step();
        #1;
    endtask

    initial begin
        int n;
        //              rd    wr    br    dw    caddr     daddr      bg    stall done  rd    wr    addr      gnt
        tab[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0040, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'd0};
        tab[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0040, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0040, 16'd0};
        tab[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0040, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0040, 16'd0};
        tab[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0040, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0040, 16'd0};
        tab[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0040, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0040, 16'd0};
        tab[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0040, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'd0};
        tab[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'd0};
        tab[7]  = '{1'b0, 1'b0, 1'b1, 1'b1, 16'h0000, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'd0};
        tab[8]  = '{1'b0, 1'b0, 1'b1, 1'b1, 16'h0000, 16'h1234, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h1234, 16'd1};
        tab[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h1234, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h1234, 16'd1};
        tab[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'd1};
        tab[11] = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'd1};
        use_tab = 0;
        reset_n = 0; rd = 1; wr = 0; br = 0; dw = 0; caddr = 16'h0040; daddr = 16'h0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_bg", bg, 1'b0);
        chk("rst_stall", cpu_stall, 1'b0);
        chk("rst_rd", mem_read_m2, 1'b0);
        chk("rst_gnt", grant_cnt, 16'h0);
        rd = 0;
        reset_n = 1;
        @(posedge clk);
        #1;
        // CPU read at 0x0040, then a plain grant/release
        use_tab = 1;
        for (int i = 0; i < 12; i++) begin
            cur = tab[i];
            rd = cur.rd; wr = cur.wr; br = cur.br; dw = cur.dw; caddr = cur.caddr; daddr = cur.daddr;
            cyc();
        end
        use_tab = 0;
        dw = 0;
        // br raised in cycle 2 of a CPU write: the write completes before the grant
        wr = 1; caddr = 16'h0200;
        cyc();
        cyc();
        br = 1;
        cyc();
        cyc();
        cyc();
        chk("t3_done_cycle4", seen_done, 1'b1);
        wr = 0;
        cyc();
        cyc();
        chk("t3_bg", bg, 1'b1);
        // CPU request during DMA ownership is stalled until release
        rd = 1; caddr = 16'h0100;
        cyc();
        chk("t4_stall", seen_done, 1'b0);
        chk("t4_stall_dma", cpu_stall, 1'b1);
        br = 0;
        n = 0;
        for (int i = 0; i < 20 && !last_done; i++) begin cyc(); n++; end
        chk("t4_done", last_done, 1'b1);
        chk("t4_latency", n, 7);
        rd = 0;
        cyc();
        cyc();
        // continuous CPU traffic with br held: burst limit forces the grant
        rd = 1; br = 1; caddr = 16'h0300;
        n = 0;
        for (int i = 0; i < 100 && bg !== 1'b1; i++) begin cyc(); if (last_done) n++; end
        chk("t5_bg", bg, 1'b1);
        chk("t5_accesses", n, MAXB);
        chk("t5_burst_cleared", dut.burst_cnt, 0);
        // asynchronous reset while DMA owns the bus
        rd = 1; dw = 1; daddr = 16'hBEEF;
        #2;
        reset_n = 0;
        #1;
        chk("t6_bg", bg, 1'b0);
        chk("t6_wr", mem_write_m2, 1'b0);
        chk("t6_addr", mem_address2, 16'h0);
        chk("t6_sel", data_sel_dma, 1'b0);
        chk("t6_stall", cpu_stall, 1'b0);
        chk("t6_gnt", grant_cnt, 16'h0);
        model_reset();
        rd = 0; br = 0; dw = 0;
        @(negedge clk);
        reset_n = 1;
        @(posedge clk);
        #1;
        chk("t6_state", dut.state, 3'd0);
        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            if (!(rd | wr) && $urandom_range(0, 2) == 0) begin
                if ($urandom_range(0, 1) == 0) rd = 1; else wr = 1;
                caddr = 16'($urandom);
            end
            if ($urandom_range(0, 7) == 0) br = ~br;
            dw = 1'($urandom);
            daddr = 16'($urandom);
            cyc();
            if (last_done) begin rd = 0; wr = 0; end
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
